// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timing constants for the multi-key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // 20 ms debounce window and 1 s long-press threshold at 50 MHz.
  localparam int unsigned CNT_MAX_DEF  = 999_999;
  localparam int unsigned LONG_MAX_DEF = 49_999_999;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: 2-FF synchroniser, debounce FSM, pulse/level/toggle outputs.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
  parameter int unsigned LONG_MAX = LONG_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_p,
  output logic key_level,
  output logic press_pulse,
  output logic rel_pulse,
  output logic toggle,
  output logic long_pulse
);

  localparam int unsigned CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  logic [1:0]    sync;
  logic          p;
  key_state_t    state;
  logic [CW-1:0] cnt;
  logic          cnt_done;
  logic          press_fire;

  assign p          = sync[1];
  assign cnt_done   = (cnt == CW'(CNT_MAX));
  assign press_fire = (state == PRESS_WAIT) && p && cnt_done;

  // Input is already polarity-normalised, so reset value 0 means "not pressed".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], key_p};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      press_pulse <= 1'b0;
      rel_pulse   <= 1'b0;
      toggle      <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      rel_pulse   <= 1'b0;
      case (state)
        IDLE: begin
          if (p) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state <= IDLE;
          end else if (cnt_done) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            toggle      <= ~toggle;
            key_level   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!p) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (p) begin
            state <= PRESSED;
          end else if (cnt_done) begin
            state     <= IDLE;
            rel_pulse <= 1'b1;
            key_level <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LW = (LONG_MAX < 1) ? 1 : $clog2(LONG_MAX + 1);

  logic [LW-1:0] hcnt;
  logic          held;

  assign held = (state == PRESSED) || (state == RELEASE_WAIT);

  // Counter parks at LONG_MAX, so only the next accepted press can re-arm it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (press_fire) begin
        hcnt <= '0;
      end else if (held && (hcnt != LW'(LONG_MAX))) begin
        hcnt <= hcnt + LW'(1);
        if (hcnt == LW'(LONG_MAX - 1)) long_pulse <= 1'b1;
      end
    end
  end
`else
  logic unused_long;
  assign unused_long = press_fire ^ (LONG_MAX == 0);
  assign long_pulse  = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button front end: polarity normalisation plus one key_debounce_ch per key.
// Define KEY_LONG_PRESS_EN to enable the per-channel long_pulse output.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned LONG_MAX   = LONG_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] rel_pulse,
  output logic [N_KEYS-1:0] toggle,
  output logic [N_KEYS-1:0] long_pulse
);

  logic [N_KEYS-1:0] key_p;

  assign key_p = ACTIVE_LOW ? ~key_in : key_in;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_p       (key_p[i]),
      .key_level   (key_level[i]),
      .press_pulse (press_pulse[i]),
      .rel_pulse   (rel_pulse[i]),
      .toggle      (toggle[i]),
      .long_pulse  (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with CNT_MAX=4, LONG_MAX=20, four active-low keys.
module tb_key_debounce_multi;

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] press_pulse;
  logic [3:0] rel_pulse;
  logic [3:0] toggle;
  logic [3:0] long_pulse;

  int checks   = 0;
  int failures = 0;

  logic [3:0] pp_h [0:63];
  logic [3:0] rp_h [0:63];
  logic [3:0] lp_h [0:63];

  key_debounce_multi #(
    .N_KEYS     (4),
    .CNT_MAX    (4),
    .ACTIVE_LOW (1'b1),
    .LONG_MAX   (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .press_pulse (press_pulse),
    .rel_pulse   (rel_pulse),
    .toggle      (toggle),
    .long_pulse  (long_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  // Record pulses after each of the next n rising edges; index k = after edge k.
  task automatic sample(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      pp_h[i] = press_pulse;
      rp_h[i] = rel_pulse;
      lp_h[i] = long_pulse;
    end
  endtask

  function automatic int ones(input int which, input int b, input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) begin
      case (which)
        0:       c += int'(pp_h[i][b]);
        1:       c += int'(rp_h[i][b]);
        default: c += int'(lp_h[i][b]);
      endcase
    end
    return c;
  endfunction

  task automatic check_all_zero(input string tag);
    check(tag, {12'd0, key_level, press_pulse, rel_pulse, toggle, long_pulse}, 32'd0);
  endtask

  initial begin
    int bad;
    int pcnt;
    int lcnt;
    logic [6:0] bounce;

    rst    = 1'b1;
    key_in = 4'hF;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;

    // 1. idle after reset
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({key_level, press_pulse, rel_pulse, toggle, long_pulse} != 20'd0) bad++;
    end
    check("idle_100", bad, 0);

    // 2. clean press on key 0
    key_in[0] = 1'b0;
    sample(12);
    check("t2_pp_at7", {28'd0, pp_h[7]}, 32'h0);
    check("t2_pp_at8", {28'd0, pp_h[8]}, 32'h1);
    check("t2_pp_at9", {28'd0, pp_h[9]}, 32'h0);
    check("t2_pp_count", ones(0, 0, 12), 1);
    check("t2_level", {28'd0, key_level}, 32'h1);
    check("t2_toggle", {28'd0, toggle}, 32'h1);

    // 3. bouncing key 1: low 3, high 1, low 3, then high
    bounce = 7'b1110111;
    bad    = 0;
    for (int i = 0; i < 7; i++) begin
      key_in[1] = ~bounce[i];
      @(negedge clk);
      if (press_pulse[1] || rel_pulse[1] || key_level[1]) bad++;
    end
    key_in[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (press_pulse[1] || rel_pulse[1] || key_level[1]) bad++;
    end
    check("t3_bounce_quiet", bad, 0);
    check("t3_level", {28'd0, key_level}, 32'h1);

    // 4. key 2 press, release after 10 cycles, second press
    key_in[2] = 1'b0;
    sample(10);
    check("t4_pp_at8", {28'd0, pp_h[8]}, 32'h4);
    key_in[2] = 1'b1;
    sample(12);
    check("t4_rp_at7", {28'd0, rp_h[7]}, 32'h0);
    check("t4_rp_at8", {28'd0, rp_h[8]}, 32'h4);
    check("t4_rp_count", ones(1, 2, 12), 1);
    check("t4_level_rel", {31'd0, key_level[2]}, 32'h0);
    check("t4_toggle_1", {31'd0, toggle[2]}, 32'h1);
    key_in[2] = 1'b0;
    sample(10);
    check("t4_pp2_at8", {28'd0, pp_h[8]}, 32'h4);
    check("t4_toggle_0", {31'd0, toggle[2]}, 32'h0);
    key_in[2] = 1'b1;
    sample(12);

    // 5. simultaneous press on keys 0 and 3
    key_in[0] = 1'b1;
    sample(12);
    check("t5_rp0_at8", {28'd0, rp_h[8]}, 32'h1);
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    sample(10);
    check("t5_pp_at7", {28'd0, pp_h[7]}, 32'h0);
    check("t5_pp_at8", {28'd0, pp_h[8]}, 32'h9);
    check("t5_toggle", {28'd0, toggle}, 32'h8);
    check("t5_level", {28'd0, key_level}, 32'h9);
    key_in[0] = 1'b1;
    key_in[3] = 1'b1;
    sample(12);
    check("t5_rp_at8", {28'd0, rp_h[8]}, 32'h9);
    check("t5_level_rel", {28'd0, key_level}, 32'h0);

    // 6. hold key 1 for 40 cycles, then reset mid-hold
    key_in[1] = 1'b0;
    sample(40);
    check("t6_pp_at8", {28'd0, pp_h[8]}, 32'h2);
    pcnt = ones(0, 1, 40);
    check("t6_single_press", pcnt, 1);
    lcnt = ones(2, 1, 40);
`ifdef KEY_LONG_PRESS_EN
    check("t6_lp_at27", {28'd0, lp_h[27]}, 32'h0);
    check("t6_lp_at28", {28'd0, lp_h[28]}, 32'h2);
    check("t6_lp_count", lcnt, 1);
`else
    check("t6_lp_none", lcnt, 0);
`endif
    check("t6_toggle", {28'd0, toggle}, 32'hA);
    rst = 1'b1;
    #1;
    check_all_zero("t6_async_reset");
    repeat (2) @(negedge clk);
    check_all_zero("t6_reset_hold");
    rst = 1'b0;
    sample(12);
    check("t6_repress_at8", {28'd0, pp_h[8]}, 32'h2);
    check("t6_toggle_after", {28'd0, toggle}, 32'h2);
    check("t6_level_after", {28'd0, key_level}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
